m_outputmux: RTL and testbench
==============================

Name: m_outputmux

Overview:
- Write-side counterpart of the core input path.
- Accepts core store requests and decodes the target address:
  - System-register window (MIP/MIE/MSTATUS) is updated locally and acked in-block.
  - All other addresses are forwarded to the external data port as a single Wishbone-style write cycle with ACK wait and timeout.
- Also owns the architectural enable/pending bits that the read mux reflects.

Parameters:
- HAS_SYSREG, 1: 1 = MIP/MIE/MSTATUS window decoded locally; 0 = every write goes external and all sysreg outputs are constant 0.
- TIMEOUT, 15: cycles to wait for ACK_I before erroring; 0 = wait forever; max 255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_req  in  1  core write request, level, held until wr_ack or wr_err
- wr_adr  in  32  core write address
- wr_dat  in  32  core write data
- wr_sel  in  4  byte enables, bit n covers [8n+7:8n]
- wr_ack  out  1  one-cycle write-complete pulse
- wr_err  out  1  one-cycle timeout pulse
- STB_O  out  1  external strobe
- WE_O  out  1  external write enable, equals STB_O
- ADR_O  out  32  latched address
- DAT_O  out  32  latched data
- SEL_O  out  4  latched byte enables
- ACK_I  in  1  external acknowledge
- trap_enter  in  1  trap taken: mpie<=mie, mie<=0
- mret  in  1  trap return: mie<=mpie, mpie<=1
- mie, mpie, meie, msie, mtie, mtimeincie, mrinstretie, msip  out  1 each  architectural register bits

Behaviour:
- Reset: all outputs 0; FSM to IDLE. rst asserted mid-cycle forces STB_O=0 on the next edge. A pending request is dropped without ack or err.
- Sysreg hit: HAS_SYSREG & wr_adr[29:27] ∈ {101,110,111}.
  - 101 = MIP, 110 = MIE, 111 = MSTATUS.
  - Bit map, identical to the read mux:
    - MIP: msip=bit3.
    - MIE: msie=3, mtie=7, meie=11, mtimeincie=16, mrinstretie=17.
    - MSTATUS: mie=3, mpie=7.
  - Bits 3 and 7 update only if wr_sel[0]; bit 11 only if wr_sel[1]; bits 16 and 17 only if wr_sel[2].
  - All other bits are ignored.
- FSM states:
  - IDLE:
    - wr_req & sysreg hit: update bits on this edge, go to ACK.
    - wr_req & no hit: latch ADR_O/DAT_O/SEL_O, set STB_O=WE_O=1, clear timer, go to BUS.
  - BUS:
    - ACK_I: drop STB_O, go to ACK.
    - Otherwise, if TIMEOUT != 0, increment timer. When timer == TIMEOUT-1 with no ACK_I: drop STB_O, go to ERR.
    - ACK_I takes priority over timeout in the same cycle.
  - ACK: wr_ack=1, go to WAITREL.
  - ERR: wr_err=1, go to WAITREL.
  - WAITREL: one dead cycle so the core can drop wr_req, then IDLE.
- Latency:
  - Sysreg write: wr_ack 1 cycle after the request edge.
  - External write: wr_ack 1 cycle after the ACK_I edge.
  - Minimum STB_O width: 1 cycle.
- ADR_O/DAT_O/SEL_O hold their last value outside BUS.
- ACK_I outside BUS is ignored.
- trap_enter and mret:
  - Act on the edge where they are sampled.
  - Take priority over a same-cycle sysreg write to mie/mpie. Other bits in that write still apply.
  - trap_enter & mret together: trap_enter wins.
- wr_req & ~wr_sel (all zero) is still a legal request: a sysreg write changes no bits but acks; an external write is still issued.

Test Plan:
- Reset then wr_req to adr 0x3000_0000 (MIE) with dat 0x0003_0888, sel 4'hF -> wr_ack next cycle; msie, mtie, meie, mtimeincie, mrinstretie all 1; STB_O stays 0.
- MSTATUS write dat 0x88, sel 4'h1, then trap_enter -> mie=1,mpie=1 after the write; after trap_enter mie=0, mpie=1. Then mret -> mie=1, mpie=1.
- External write adr 0x0000_0040, dat 0xDEADBEEF, sel 4'h3 with ACK_I after 3 cycles:
  - STB_O high exactly 3 cycles, ADR_O=0x40, DAT_O=0xDEADBEEF, SEL_O=4'h3.
  - wr_ack 1 cycle later; no wr_err.
- TIMEOUT=15, no ACK_I -> STB_O high 15 cycles, then wr_err pulse 1 cycle, then IDLE; no wr_ack.
- Sysreg MIE write with sel 4'h4 and dat 0x0003_0888 -> only mtimeincie and mrinstretie set; msie, mtie, meie unchanged.
- rst asserted in BUS cycle 2 -> STB_O=0 next cycle, no wr_ack/wr_err, all sysreg bits 0. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/m_outputmux.sv
// Core store path: decodes the MIP/MIE/MSTATUS window locally and forwards all
// other writes as one Wishbone-style write cycle with ACK wait and timeout.
module m_outputmux #(
  parameter int unsigned HAS_SYSREG = 1,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] wr_adr,
  input  logic [31:0] wr_dat,
  input  logic [3:0]  wr_sel,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic        ACK_I,
  input  logic        trap_enter,
  input  logic        mret,
  output logic        mie,
  output logic        mpie,
  output logic        meie,
  output logic        msie,
  output logic        mtie,
  output logic        mtimeincie,
  output logic        mrinstretie,
  output logic        msip,
  output logic [2:0]  state_o
);

  // Core side: wr_req is a level held until the one-cycle wr_ack or wr_err
  // pulse; the external side holds STB_O/WE_O until ACK_I or timeout.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUS     = 3'd1,
    S_ACK     = 3'd2,
    S_ERR     = 3'd3,
    S_WAITREL = 3'd4
  } state_t;

  localparam logic       SYS_EN = (HAS_SYSREG != 0);
  localparam logic       T_EN   = (TIMEOUT != 0);
  localparam logic [7:0] T_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, msie_q, msie_d;
  logic        mtie_q, mtie_d, mti_q, mti_d, mri_q, mri_d, msip_q, msip_d;
  logic        sys_hit, sys_wr;

  assign sys_hit = SYS_EN && ((wr_adr[29:28] == 2'b11) || (wr_adr[29:27] == 3'b101));
  assign sys_wr  = (state_q == S_IDLE) && wr_req && sys_hit;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          if (sys_hit) begin
            state_d = S_ACK;
          end else begin
            adr_d   = wr_adr;
            dat_d   = wr_dat;
            sel_d   = wr_sel;
            timer_d = 8'd0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // ACK_I wins over an expiring timer in the same cycle.
        if (ACK_I) begin
          state_d = S_ACK;
        end else if (T_EN) begin
          if (timer_q == T_LAST) state_d = S_ERR;
          else                   timer_d = timer_q + 8'd1;
        end
      end
      S_ACK:     state_d = S_WAITREL;
      S_ERR:     state_d = S_WAITREL;
      S_WAITREL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mie_d  = mie_q;
    mpie_d = mpie_q;
    meie_d = meie_q;
    msie_d = msie_q;
    mtie_d = mtie_q;
    mti_d  = mti_q;
    mri_d  = mri_q;
    msip_d = msip_q;
    if (sys_wr) begin
      unique case (wr_adr[29:27])
        3'b101: if (wr_sel[0]) msip_d = wr_dat[3];
        3'b110: begin
          if (wr_sel[0]) begin
            msie_d = wr_dat[3];
            mtie_d = wr_dat[7];
          end
          if (wr_sel[1]) meie_d = wr_dat[11];
          if (wr_sel[2]) begin
            mti_d = wr_dat[16];
            mri_d = wr_dat[17];
          end
        end
        3'b111: if (wr_sel[0]) begin
          mie_d  = wr_dat[3];
          mpie_d = wr_dat[7];
        end
        default: ;
      endcase
    end
    // Trap entry/return override any same-cycle MSTATUS write; entry wins.
    if (trap_enter) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (!SYS_EN) begin
      mie_d  = 1'b0;
      mpie_d = 1'b0;
      meie_d = 1'b0;
      msie_d = 1'b0;
      mtie_d = 1'b0;
      mti_d  = 1'b0;
      mri_d  = 1'b0;
      msip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      meie_q  <= 1'b0;
      msie_q  <= 1'b0;
      mtie_q  <= 1'b0;
      mti_q   <= 1'b0;
      mri_q   <= 1'b0;
      msip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      meie_q  <= meie_d;
      msie_q  <= msie_d;
      mtie_q  <= mtie_d;
      mti_q   <= mti_d;
      mri_q   <= mri_d;
      msip_q  <= msip_d;
    end
  end

  assign wr_ack      = (state_q == S_ACK);
  assign wr_err      = (state_q == S_ERR);
  assign STB_O       = (state_q == S_BUS);
  assign WE_O        = STB_O;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign SEL_O       = sel_q;
  assign mie         = mie_q;
  assign mpie        = mpie_q;
  assign meie        = meie_q;
  assign msie        = msie_q;
  assign mtie        = mtie_q;
  assign mtimeincie  = mti_q;
  assign mrinstretie = mri_q;
  assign msip        = msip_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_m_outputmux.sv
// Directed bench for m_outputmux: sysreg window writes, trap/mret, external
// write with ACK, timeout, and reset in the middle of a bus cycle.
module tb_m_outputmux;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [31:0] wr_adr, wr_dat;
  logic [3:0]  wr_sel;
  logic        wr_ack, wr_err, STB_O, WE_O, ACK_I, trap_enter, mret;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic        mie, mpie, meie, msie, mtie, mtimeincie, mrinstretie, msip;
  logic [2:0]  state_o;
  logic [7:0]  bits;

  int n_checks = 0;
  int n_err    = 0;

  m_outputmux #(.HAS_SYSREG(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_sel(wr_sel),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .ACK_I(ACK_I), .trap_enter(trap_enter), .mret(mret),
    .mie(mie), .mpie(mpie), .meie(meie), .msie(msie), .mtie(mtie),
    .mtimeincie(mtimeincie), .mrinstretie(mrinstretie), .msip(msip),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Bit order: {mie, mpie, meie, msie, mtie, mtimeincie, mrinstretie, msip}
  assign bits = {mie, mpie, meie, msie, mtie, mtimeincie, mrinstretie, msip};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sysreg write: ack one cycle after the request edge, no strobe, then release.
  task automatic sys_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [7:0] exp_bits);
    wr_req = 1'b1; wr_adr = adr; wr_dat = dat; wr_sel = sel;
    tick();
    chk({tag, "_ack"}, wr_ack, 1'b1);
    chk({tag, "_stb"}, STB_O, 1'b0);
    chk({tag, "_bits"}, bits, exp_bits);
    wr_req = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, wr_ack, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_adr = '0; wr_dat = '0; wr_sel = '0;
    ACK_I = 1'b0; trap_enter = 1'b0; mret = 1'b0;
    tick();
    tick();
    chk("rst_ack", wr_ack, 1'b0);
    chk("rst_err", wr_err, 1'b0);
    chk("rst_stb", STB_O, 1'b0);
    chk("rst_adr", ADR_O, 32'h0);
    chk("rst_bits", bits, 8'h00);
    chk("rst_state", state_o, 3'd0);
    rst = 1'b0;
    tick();

    // MIE write, all lanes
    sys_write("mie_all", 32'h3000_0000, 32'h0003_0888, 4'hF, 8'h3E);

    // MSTATUS write then trap / mret
    sys_write("mstatus", 32'h3800_0000, 32'h0000_0088, 4'h1, 8'hFE);
    trap_enter = 1'b1; tick(); trap_enter = 1'b0;
    chk("trap", bits, 8'h7E);
    mret = 1'b1; tick(); mret = 1'b0;
    chk("mret", bits, 8'hFE);
    trap_enter = 1'b1; mret = 1'b1; tick(); trap_enter = 1'b0; mret = 1'b0;
    chk("trap_and_mret", bits, 8'h7E);
    mret = 1'b1; tick(); mret = 1'b0;
    chk("mret2", bits, 8'hFE);
    // Trap in the same cycle as an MSTATUS write clearing mie/mpie
    trap_enter = 1'b1;
    wr_req = 1'b1; wr_adr = 32'h3800_0000; wr_dat = 32'h0; wr_sel = 4'h1;
    tick();
    trap_enter = 1'b0;
    chk("trap_vs_wr_ack", wr_ack, 1'b1);
    chk("trap_vs_wr_bits", bits, 8'h7E);
    wr_req = 1'b0;
    tick();
    tick();

    // External write, ACK_I in the third strobe cycle
    wr_req = 1'b1; wr_adr = 32'h0000_0040; wr_dat = 32'hDEAD_BEEF; wr_sel = 4'h3;
    tick();
    chk("ext_stb1", STB_O, 1'b1);
    chk("ext_we", WE_O, 1'b1);
    chk("ext_adr", ADR_O, 32'h0000_0040);
    chk("ext_dat", DAT_O, 32'hDEAD_BEEF);
    chk("ext_sel", SEL_O, 4'h3);
    chk("ext_no_early_ack", wr_ack, 1'b0);
    tick();
    chk("ext_stb2", STB_O, 1'b1);
    tick();
    chk("ext_stb3", STB_O, 1'b1);
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    chk("ext_stb_drop", STB_O, 1'b0);
    chk("ext_ack", wr_ack, 1'b1);
    chk("ext_no_err", wr_err, 1'b0);
    wr_req = 1'b0;
    tick();
    chk("ext_ack_drop", wr_ack, 1'b0);
    chk("ext_adr_hold", ADR_O, 32'h0000_0040);
    tick();
    chk("ext_idle", state_o, 3'd0);

    // Stray ACK_I while idle
    ACK_I = 1'b1; tick(); ACK_I = 1'b0;
    chk("stray_ack", wr_ack, 1'b0);
    tick();

    // Timeout: 15 strobe cycles, then one wr_err pulse
    wr_req = 1'b1; wr_adr = 32'h0000_0100; wr_dat = 32'h1234_5678; wr_sel = 4'hF;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("to_stb%0d", i + 1), STB_O, 1'b1);
      chk($sformatf("to_noerr%0d", i + 1), wr_err, 1'b0);
    end
    tick();
    chk("to_stb_drop", STB_O, 1'b0);
    chk("to_err", wr_err, 1'b1);
    chk("to_no_ack", wr_ack, 1'b0);
    wr_req = 1'b0;
    tick();
    chk("to_err_drop", wr_err, 1'b0);
    tick();
    chk("to_idle", state_o, 3'd0);

    // Byte-lane gating on MIE and MIP
    sys_write("mie_clr", 32'h3000_0000, 32'h0, 4'hF, 8'h40);
    sys_write("mie_sel4", 32'h3000_0000, 32'h0003_0888, 4'h4, 8'h46);
    sys_write("mip_set", 32'h2800_0000, 32'h0000_0008, 4'h1, 8'h47);
    sys_write("mip_sel0", 32'h2800_0000, 32'h0, 4'h0, 8'h47);

    // Reset in BUS cycle 2
    wr_req = 1'b1; wr_adr = 32'h0000_0080; wr_dat = 32'hCAFE_F00D; wr_sel = 4'hF;
    tick();
    chk("rb_stb1", STB_O, 1'b1);
    tick();
    chk("rb_stb2", STB_O, 1'b1);
    rst = 1'b1; wr_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rb_stb", STB_O, 1'b0);
    chk("rb_ack", wr_ack, 1'b0);
    chk("rb_err", wr_err, 1'b0);
    chk("rb_bits", bits, 8'h00);
    chk("rb_adr", ADR_O, 32'h0);
    tick();
    chk("rb_ack2", wr_ack, 1'b0);
    chk("rb_err2", wr_err, 1'b0);

    // Fresh external write with a one-cycle strobe
    wr_req = 1'b1; wr_adr = 32'h0000_0044; wr_dat = 32'h1122_3344; wr_sel = 4'hF;
    tick();
    chk("fr_stb", STB_O, 1'b1);
    chk("fr_adr", ADR_O, 32'h0000_0044);
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    chk("fr_ack", wr_ack, 1'b1);
    chk("fr_stb_drop", STB_O, 1'b0);
    wr_req = 1'b0;
    tick();
    tick();
    chk("fr_idle", state_o, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
